// File: rtl/regfile_param_sweep.sv
// Parametrised register file with two combinational read ports and one synchronous write port.
// A small sweep FSM zeroes every entry after reset or on request, flagging busy while it runs.
module regfile_param_sweep #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  input  logic [AW-1:0]   a3,
  input  logic [XLEN-1:0] wd3,
  input  logic            we3,
  input  logic            clr_req,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   cnt;
  logic [AW-1:0]   cnt_nxt;
  logic [XLEN-1:0] mem [NREG];
  logic            wr_ok;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        // cnt wraps to 0 on its own at LAST because NREG is a power of two.
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) state_nxt = IDLE;
      end
    endcase
  end

  assign busy  = !rst || (state == CLEAR);
  assign wr_ok = we3 && !((ZERO_REG != 0) && (a3 == '0));

  // NOTE: the array has no reset branch; the sweep clears it, so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == CLEAR) begin
        mem[cnt] <= '0;
      end else if (wr_ok) begin
        mem[a3] <= wd3;
      end
    end
  end

  // Read priority: hardwired zero, then same-cycle bypass, then stored data.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (!busy) begin
      if ((ZERO_REG != 0) && (a1 == '0))            rd1 = '0;
      else if ((BYPASS != 0) && we3 && (a3 == a1)) rd1 = wd3;
      else                                         rd1 = mem[a1];

      if ((ZERO_REG != 0) && (a2 == '0))            rd2 = '0;
      else if ((BYPASS != 0) && we3 && (a3 == a2)) rd2 = wd3;
      else                                         rd2 = mem[a2];
    end
  end

endmodule

// File: tb/tb_regfile_param_sweep.sv
// Self-checking bench: default, no-bypass and 64-bit/16-entry/no-zero-reg variants of the register file.
// Read expectations come from a bench-side model and flow through a scoreboard queue.
module tb_regfile_param_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  a1, a2, a3;
  logic [31:0] wd3;
  logic        we3, clr_req;
  logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
  logic        busy, busy_nb;

  logic [3:0]  b1, b2, b3;
  logic [63:0] wd3_w, rd1_w, rd2_w;
  logic        we3_w, clr_w, busy_w;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];

  regfile_param_sweep dut (
    .clk(clk), .rst(rst), .a1(a1), .a2(a2), .a3(a3), .wd3(wd3), .we3(we3),
    .clr_req(clr_req), .rd1(rd1), .rd2(rd2), .busy(busy)
  );

  regfile_param_sweep #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .a1(a1), .a2(a2), .a3(a3), .wd3(wd3), .we3(we3),
    .clr_req(clr_req), .rd1(rd1_nb), .rd2(rd2_nb), .busy(busy_nb)
  );

  regfile_param_sweep #(.XLEN(64), .NREG(16), .AW(4), .ZERO_REG(0)) dut64 (
    .clk(clk), .rst(rst), .a1(b1), .a2(b2), .a3(b3), .wd3(wd3_w), .we3(we3_w),
    .clr_req(clr_w), .rd1(rd1_w), .rd2(rd2_w), .busy(busy_w)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [63:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
    a3 = addr; wd3 = data; we3 = 1'b1;
    tick();
    we3 = 1'b0;
    if (addr != 5'd0) model[addr] = data;
  endtask

  // Reads both ports of both 32-bit instances against the model (entry 0 is hardwired zero).
  task automatic read_check(input string tag, input logic [4:0] x, input logic [4:0] y);
    a1 = x; a2 = y;
    #1;
    push({tag, "_rd1"},    (x == 5'd0) ? 32'd0 : model[x]);
    push({tag, "_rd2"},    (y == 5'd0) ? 32'd0 : model[y]);
    push({tag, "_nb_rd1"}, (x == 5'd0) ? 32'd0 : model[x]);
    push({tag, "_nb_rd2"}, (y == 5'd0) ? 32'd0 : model[y]);
    pop_check(rd1);
    pop_check(rd2);
    pop_check(rd1_nb);
    pop_check(rd2_nb);
  endtask

  // Counts posedges until busy falls; also records when the 64-bit instance's busy fell.
  task automatic count_sweep(output int n, output int n64);
    n = 100;
    n64 = 100;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (n64 == 100 && !busy_w) n64 = i;
      if (busy) begin
        push("sweep_rd1", 64'd0);
        pop_check(rd1);
      end else begin
        n = i;
        break;
      end
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n64;
    rst = 1'b0; a1 = 5'd5; a2 = 5'd7; a3 = '0; wd3 = '0; we3 = 1'b0; clr_req = 1'b0;
    b1 = '0; b2 = '0; b3 = '0; wd3_w = '0; we3_w = 1'b0; clr_w = 1'b0;
    clear_model();

    // Reset held for three edges: busy high, reads forced to zero.
    #1;
    check("rst_busy_t0", busy, 1'b1);
    repeat (3) tick();
    check("rst_busy", busy, 1'b1);
    check("rst_busy64", busy_w, 1'b1);
    push("rst_rd1", 64'd0); pop_check(rd1);
    push("rst_rd2", 64'd0); pop_check(rd2);

    // Release: sweep lasts NREG edges on each instance.
    rst = 1'b1;
    count_sweep(n, n64);
    check("sweep_len", 64'(n), 64'd32);
    check("sweep_len64", 64'(n64), 64'd16);
    check("nb_idle", busy_nb, 1'b0);
    for (int i = 0; i < 32; i++) read_check("post_rst", 5'(i), 5'(31 - i));
    for (int i = 0; i < 16; i++) begin
      b1 = 4'(i);
      #1;
      push("post_rst64", 64'd0);
      pop_check(rd1_w);
    end

    // Plain write/read and the hardwired-zero entry.
    do_write(5'd5, 32'hDEADBEEF);
    read_check("wr5", 5'd5, 5'd6);
    do_write(5'd0, 32'h0000_1234);
    read_check("wr0", 5'd5, 5'd0);
    do_write(5'd31, 32'h8000_0001);
    read_check("wr31", 5'd31, 5'd31);

    // Same-cycle bypass: forwarded on the default instance, old value on the no-bypass one.
    a1 = 5'd7; a2 = 5'd7; a3 = 5'd7; wd3 = 32'hA5A5A5A5; we3 = 1'b1;
    #1;
    push("byp_rd1", 64'hA5A5A5A5);    pop_check(rd1);
    push("byp_rd2", 64'hA5A5A5A5);    pop_check(rd2);
    push("nobyp_rd1", 64'(model[7])); pop_check(rd1_nb);
    push("nobyp_rd2", 64'(model[7])); pop_check(rd2_nb);
    tick();
    we3 = 1'b0;
    model[7] = 32'hA5A5A5A5;
    read_check("byp_stored", 5'd7, 5'd5);

    // Clear request with a coincident write; writes issued mid-sweep must be dropped.
    do_write(5'd3, 32'h11);
    a3 = 5'd4; wd3 = 32'h22; we3 = 1'b1; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("clr_busy", busy, 1'b1);
    a1 = 5'd3; a3 = 5'd2; wd3 = 32'h77;
    count_sweep(n, n64);
    we3 = 1'b0;
    check("clr_len", 64'(n), 64'd32);
    clear_model();
    read_check("clr_r34", 5'd3, 5'd4);
    read_check("clr_r2", 5'd2, 5'd5);

    // Reset at sweep cycle 10 restarts the sweep from zero.
    do_write(5'd9, 32'h99);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    rst = 1'b0;
    tick();
    check("mid_rst_busy", busy, 1'b1);
    tick();
    rst = 1'b1;
    count_sweep(n, n64);
    check("restart_len", 64'(n), 64'd32);
    check("restart_len64", 64'(n64), 64'd16);
    clear_model();
    read_check("restart_r9", 5'd9, 5'd10);

    // 64-bit, 16-entry variant: entry 0 is an ordinary register.
    b3 = 4'd0; wd3_w = 64'hFFFF_FFFF_FFFF_FFFF; we3_w = 1'b1;
    tick();
    b3 = 4'd15; wd3_w = 64'h0123_4567_89AB_CDEF;
    tick();
    we3_w = 1'b0; b1 = 4'd0; b2 = 4'd15;
    #1;
    push("w64_r0", 64'hFFFF_FFFF_FFFF_FFFF);  pop_check(rd1_w);
    push("w64_r15", 64'h0123_4567_89AB_CDEF); pop_check(rd2_w);
    clr_w = 1'b1;
    tick();
    clr_w = 1'b0;
    n64 = 100;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (!busy_w) begin
        n64 = i;
        break;
      end
    end
    check("clr_len64", 64'(n64), 64'd16);
    push("clr64_r0", 64'd0);  pop_check(rd1_w);
    push("clr64_r15", 64'd0); pop_check(rd2_w);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
